dino_runner_ctrl: RTL and testbench

- Player-side counterpart to the obstacle generator in the endless-runner VGA game (640x480).
- Owns the dinosaur bounding box: fixed X, jump physics in Y.
- Consumes one obstacle's box (X, Y, width, height) and tests for overlap each frame.
- Drives the shared Stop line that freezes obstacle motion, and keeps a distance score.

---
 rtl/dino_pkg.sv | 26 ++
 rtl/dino_runner_ctrl_if.sv | 27 ++
 rtl/btn_sync_edge.sv | 50 +++++
 rtl/dino_runner_ctrl.sv | 157 +++++++++++++++
 tb/tb_dino_runner_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared constants and state encoding for the dinosaur runner controller.
// The optional crouch feature is enabled by defining DINO_DUCK_EN.
package dino_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] GROUND_Y = 10'd400;
  localparam logic [9:0] DINO_X   = 10'd80;
  localparam logic [9:0] DINO_W   = 10'd20;
  localparam logic [9:0] DINO_H   = 10'd22;
  localparam logic [9:0] DUCK_H   = 10'd12;
  localparam logic [9:0] STAND_Y  = GROUND_Y - DINO_H;  // 378
  localparam logic [9:0] DUCK_Y   = GROUND_Y - DUCK_H;  // 388

  localparam logic [4:0]  JUMP_V0   = 5'd12;
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  // Vertical direction lives in the state; velocity is a plain magnitude.
  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RISE,
    FALL,
    DEAD
  } state_t;

endpackage

// File: rtl/dino_runner_ctrl_if.sv
// Box exchange between the dino controller and the obstacle generator:
// obstacle box in, dino box and the shared Stop line out.
interface dino_runner_ctrl_if;

  logic [9:0] Obs_X;
  logic [9:0] Obs_Y;
  logic [9:0] Obs_W;
  logic [9:0] Obs_H;
  logic [9:0] Point_X;
  logic [9:0] Point_Y;
  logic [9:0] Width;
  logic [9:0] Heigh;
  logic       Stop;

  // Dino side.
  modport master (
    input  Obs_X, Obs_Y, Obs_W, Obs_H,
    output Point_X, Point_Y, Width, Heigh, Stop
  );

  // Obstacle side.
  modport slave (
    output Obs_X, Obs_Y, Obs_W, Obs_H,
    input  Point_X, Point_Y, Width, Heigh, Stop
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw push-button. With LEVEL = 0 the output
// is a registered one-cycle pulse on each rising edge (3 cycles after the
// pin); with LEVEL = 1 it is the synchronized level.
module btn_sync_edge #(
  parameter bit LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic sync1_q;
  logic sync2_q;

  // Metastability guard: two back-to-back flops on the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments keep the flop chain a true shift register.
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (LEVEL) begin : g_level
      assign dout = sync2_q;
    end else begin : g_edge
      logic prev_q;
      logic pulse_q;

      // Registered rising-edge detect on the synchronized level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          prev_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          prev_q  <= sync2_q;
          pulse_q <= sync2_q & ~prev_q;
        end
      end

      assign dout = pulse_q;
    end
  endgenerate

endmodule

// File: rtl/dino_runner_ctrl.sv
// Dinosaur runner controller: jump physics, collision test against one
// obstacle box, Stop/game_over control and saturating distance score.
// Optional crouch input is enabled by defining DINO_DUCK_EN.
module dino_runner_ctrl
  import dino_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_btn,
`ifdef DINO_DUCK_EN
  input  logic                duck_btn,
`endif
  dino_runner_ctrl_if.master  bus,
  output logic                game_over,
  output logic [13:0]         score
);

  state_t      state_q, state_d;
  logic [9:0]  y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic        stop_q, stop_d;
  logic        over_q, over_d;
  logic [13:0] score_q, score_d;
  logic        jump_evt;
  logic        hit;
  logic [10:0] fall_sum;

  btn_sync_edge #(.LEVEL(1'b0)) u_jump_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (jump_btn),
    .dout (jump_evt)
  );

`ifdef DINO_DUCK_EN
  logic duck_lvl;
  logic duck_q, duck_d;

  btn_sync_edge #(.LEVEL(1'b1)) u_duck_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (duck_btn),
    .dout (duck_lvl)
  );

  // Crouch flag tracks the pose chosen in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) duck_q <= 1'b0;
    else      duck_q <= duck_d;
  end

  assign bus.Heigh = duck_q ? DUCK_H : DINO_H;
`else
  assign bus.Heigh = DINO_H;
`endif

  assign bus.Point_X = DINO_X;
  assign bus.Point_Y = y_q;
  assign bus.Width   = DINO_W;
  assign bus.Stop    = stop_q;
  assign game_over   = over_q;
  assign score       = score_q;

  // Strict inequalities on 11-bit sums: touching edges do not collide.
  assign hit = ({1'b0, DINO_X}    < ({1'b0, bus.Obs_X} + {1'b0, bus.Obs_W})) &&
               ({1'b0, bus.Obs_X} < ({1'b0, DINO_X}    + {1'b0, DINO_W}))    &&
               ({1'b0, y_q}       < ({1'b0, bus.Obs_Y} + {1'b0, bus.Obs_H})) &&
               ({1'b0, bus.Obs_Y} < ({1'b0, y_q}       + {1'b0, bus.Heigh}));

  assign fall_sum = {1'b0, y_q} + {6'd0, vel_q};

  // State and datapath registers; reset puts the dino standing, game frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= STAND_Y;
      vel_q   <= 5'd0;
      stop_q  <= 1'b1;
      over_q  <= 1'b0;
      score_q <= 14'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      stop_q  <= stop_d;
      over_q  <= over_d;
      score_q <= score_d;
    end
  end

  // Next-state, physics and score; a collision outranks any jump request.
  always_comb begin
    // NOTE: every output gets a hold default first so no latch is inferred.
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    stop_d  = stop_q;
    over_d  = over_q;
    score_d = score_q;
`ifdef DINO_DUCK_EN
    duck_d  = duck_q;
`endif

    case (state_q)
      IDLE: begin
        // The first press only starts the game.
        if (jump_evt) begin
          state_d = RUN;
          stop_d  = 1'b0;
        end
      end

      RUN, RISE, FALL: begin
        if (hit) begin
          state_d = DEAD;
          stop_d  = 1'b1;
          over_d  = 1'b1;
        end else begin
          score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
          if (state_q == RUN) begin
`ifdef DINO_DUCK_EN
            duck_d = duck_lvl;
            y_d    = duck_lvl ? DUCK_Y : STAND_Y;
            if (jump_evt && !duck_lvl) begin
              state_d = RISE;
              vel_d   = JUMP_V0;
            end
`else
            if (jump_evt) begin
              state_d = RISE;
              vel_d   = JUMP_V0;
            end
`endif
          end else if (state_q == RISE) begin
            y_d = y_q - {5'd0, vel_q};
            if (vel_q == 5'd1) state_d = FALL;
            else               vel_d   = vel_q - 5'd1;
          end else begin
            if (fall_sum >= {1'b0, STAND_Y}) begin
              y_d     = STAND_Y;
              vel_d   = 5'd0;
              state_d = RUN;
            end else begin
              y_d   = fall_sum[9:0];
              vel_d = (vel_q == JUMP_V0) ? JUMP_V0 : vel_q + 5'd1;
            end
          end
        end
      end

      DEAD: ;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dino_runner_ctrl.sv
// Directed bench for dino_runner_ctrl: start, jump profile, collisions,
// touching edges, hit-vs-jump priority, score saturation, async reset.
module tb_dino_runner_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_btn;
  logic        duck_btn;
  logic        game_over;
  logic [13:0] score;

  int checks = 0;
  int errors = 0;

  dino_runner_ctrl_if bus ();

  dino_runner_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .jump_btn  (jump_btn),
`ifdef DINO_DUCK_EN
    .duck_btn  (duck_btn),
`endif
    .bus       (bus),
    .game_over (game_over),
    .score     (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; returns 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [9:0] obs_x);
    rst       = 1'b0;
    jump_btn  = 1'b0;
    duck_btn  = 1'b0;
    bus.Obs_X = obs_x;
    bus.Obs_Y = 10'd367;
    bus.Obs_W = 10'd15;
    bus.Obs_H = 10'd33;
    tick(2);
    rst = 1'b1;
  endtask

  // Press the button; the registered pulse is high after the 3rd edge.
  task automatic press_to_pulse();
    jump_btn = 1'b1;
    tick(2);
    jump_btn = 1'b0;
    tick(1);
  endtask

  int rise_y [12] = '{366, 355, 345, 336, 328, 321, 315, 310, 306, 303, 301, 300};
  int fall_y [12] = '{301, 303, 306, 310, 315, 321, 328, 336, 345, 355, 366, 378};

  initial begin
    do_reset(10'd640);

    // Reset values while reset is still asserted.
    rst = 1'b0;
    #1;
    check("rst_point_y", bus.Point_Y, 378);
    check("rst_stop", bus.Stop, 1);
    check("rst_game_over", game_over, 0);
    check("rst_score", score, 0);
    check("rst_point_x", bus.Point_X, 80);
    check("rst_width", bus.Width, 20);
    check("rst_heigh", bus.Heigh, 22);
    tick(1);
    rst = 1'b1;

    // Start press: Stop drops on the 4th edge after the press.
    press_to_pulse();
    check("start_stop_held", bus.Stop, 1);
    tick(1);
    check("start_stop_low", bus.Stop, 0);
    check("start_point_y", bus.Point_Y, 378);
    check("start_score0", score, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check($sformatf("score_count_%0d", i), score, i);
    end

    // Jump: no move on the request edge, then 12 rise and 12 fall frames.
    press_to_pulse();
    tick(1);
    check("jump_req_y", bus.Point_Y, 378);
    check("jump_req_score", score, 7);
    for (int i = 0; i < 24; i++) begin
      if (i == 2) jump_btn = 1'b1;
      if (i == 5) jump_btn = 1'b0;
      if (i == 12) bus.Obs_X = 10'd90;
      if (i == 13) bus.Obs_X = 10'd640;
      tick(1);
      if (i < 12) check($sformatf("rise_%0d", i + 1), bus.Point_Y, rise_y[i]);
      else        check($sformatf("fall_%0d", i - 11), bus.Point_Y, fall_y[i - 12]);
      if (i == 12) begin
        check("apex_no_hit_stop", bus.Stop, 0);
        check("apex_no_hit_over", game_over, 0);
      end
    end
    tick(3);
    check("landed_no_rejump", bus.Point_Y, 378);
    check("landed_score", score, 34);

    // Standing collision: frozen and sticky, even with a later press.
    bus.Obs_X = 10'd90;
    tick(1);
    check("hit_stop", bus.Stop, 1);
    check("hit_over", game_over, 1);
    check("hit_score", score, 34);
    jump_btn = 1'b1;
    tick(50);
    jump_btn = 1'b0;
    tick(50);
    check("dead_score", score, 34);
    check("dead_y", bus.Point_Y, 378);
    check("dead_stop", bus.Stop, 1);
    check("dead_over", game_over, 1);

    // Overlap while IDLE is ignored; one pixel of overlap hits in RUN.
    do_reset(10'd99);
    press_to_pulse();
    check("idle_hit_over", game_over, 0);
    tick(1);
    check("idle_hit_run_stop", bus.Stop, 0);
    tick(1);
    check("overlap99_over", game_over, 1);

    // Touching edges never collide.
    do_reset(10'd100);
    press_to_pulse();
    tick(6);
    check("touch100_over", game_over, 0);
    check("touch100_stop", bus.Stop, 0);

    // Hit and jump request on the same edge: DEAD, no rise.
    press_to_pulse();
    bus.Obs_X = 10'd99;
    tick(1);
    check("simul_over", game_over, 1);
    check("simul_y", bus.Point_Y, 378);
    tick(3);
    check("simul_no_rise", bus.Point_Y, 378);

    // Score saturation.
    do_reset(10'd640);
    press_to_pulse();
    tick(1);
    tick(9998);
    check("score_9998", score, 9998);
    tick(5);
    check("score_sat", score, 9999);

    // Asynchronous reset mid-rise.
    press_to_pulse();
    tick(1);
    tick(3);
    check("mid_rise_y", bus.Point_Y, 345);
    #2;
    rst = 1'b0;
    #1;
    check("arst_point_y", bus.Point_Y, 378);
    check("arst_stop", bus.Stop, 1);
    check("arst_over", game_over, 0);
    check("arst_score", score, 0);
    tick(1);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
